// File: rtl/count_event_monitor_if.sv
// Bundle between the up/down counter side (master) and the count event monitor (slave).
// The master supplies the sampled count and the clear request, and observes the event flags.
interface count_event_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) ();
  logic [WIDTH-1:0]  count_in;
  logic              clr;
  logic              ovf;
  logic              unf;
  logic              jump;
  logic [1:0]        dir_state;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              alarm;

  modport master (
    output count_in, clr,
    input  ovf, unf, jump, dir_state, wrap_cnt, alarm
  );

  modport slave (
    input  count_in, clr,
    output ovf, unf, jump, dir_state, wrap_cnt, alarm
  );
endinterface

// File: rtl/count_event_monitor.sv
// Observes an up/down counter's count bus and classifies each transition as
// step up, step down, hold or jump. It flags wraps, tracks direction and raises a sticky alarm.
module count_event_monitor #(
  parameter int WIDTH      = 4,
  parameter int WRAP_W     = 8,
  parameter int WRAP_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  count_event_monitor_if.slave bus
);

  localparam logic [1:0]        ST_INIT  = 2'b00;
  localparam logic [1:0]        ST_HOLD  = 2'b01;
  localparam logic [1:0]        ST_UP    = 2'b10;
  localparam logic [1:0]        ST_DOWN  = 2'b11;
  localparam logic [WIDTH-1:0]  MAX_Q    = '1;
  localparam logic [WIDTH-1:0]  ONE_Q    = 1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [WRAP_W-1:0] LIMIT    = WRAP_LIMIT[WRAP_W-1:0];

  logic [WIDTH-1:0]  r_prev_q;
  logic [1:0]        r_state;
  logic              r_ovf;
  logic              r_unf;
  logic              r_jump;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_alarm;

  logic [WIDTH-1:0]  w_inc;
  logic [WIDTH-1:0]  w_dec;
  logic [1:0]        w_next_state;
  logic              w_ovf;
  logic              w_unf;
  logic              w_jump;
  logic [WRAP_W-1:0] w_wrap_next;

  // The wrap counter sticks at all-ones instead of rolling back to zero.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (v == WRAP_MAX) ? v : v + WRAP_ONE;
  endfunction

  assign w_inc = r_prev_q + ONE_Q;
  assign w_dec = r_prev_q - ONE_Q;

  // Classify the newly sampled count against the previous sample.
  always_comb begin
    w_next_state = r_state;
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    w_jump       = 1'b0;
    if (r_state == ST_INIT) begin
      w_next_state = ST_HOLD;
    end else if (bus.count_in == w_inc) begin
      w_next_state = ST_UP;
      w_ovf        = (r_prev_q == MAX_Q);
    end else if (bus.count_in == w_dec) begin
      w_next_state = ST_DOWN;
      w_unf        = (r_prev_q == '0);
    end else if (bus.count_in == r_prev_q) begin
      w_next_state = ST_HOLD;
    end else begin
      // A load gives no direction information.
      w_next_state = ST_HOLD;
      w_jump       = 1'b1;
    end
  end

  assign w_wrap_next = (w_ovf | w_unf) ? sat_inc(r_wrap_cnt) : r_wrap_cnt;

  // Register stage: clr clears the statistics and the pulses; the sample history and the FSM keep running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_q   <= '0;
      r_state    <= ST_INIT;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_jump     <= 1'b0;
      r_wrap_cnt <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_prev_q <= bus.count_in;
      r_state  <= w_next_state;
      if (bus.clr) begin
        r_ovf      <= 1'b0;
        r_unf      <= 1'b0;
        r_jump     <= 1'b0;
        r_wrap_cnt <= '0;
        r_alarm    <= 1'b0;
      end else begin
        r_ovf      <= w_ovf;
        r_unf      <= w_unf;
        r_jump     <= w_jump;
        r_wrap_cnt <= w_wrap_next;
        if (w_wrap_next >= LIMIT) r_alarm <= 1'b1;
      end
    end
  end

  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;
  assign bus.jump      = r_jump;
  assign bus.dir_state = r_state;
  assign bus.wrap_cnt  = r_wrap_cnt;
  assign bus.alarm     = r_alarm;

endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboard bench for count_event_monitor: a behavioural model pushes the expected outputs for each driven sample,
// and these are popped and compared one edge later.
module tb_count_event_monitor;

  localparam int WIDTH  = 4;
  localparam int WRAP_W = 8;
  localparam int LIMIT  = 3;
  localparam int MODV   = 1 << WIDTH;
  localparam int MAXV   = MODV - 1;
  localparam int WSAT   = (1 << WRAP_W) - 1;

  typedef struct {
    logic       ovf;
    logic       unf;
    logic       jump;
    logic [1:0] st;
    int         wrap;
    logic       alarm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  count_event_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  count_event_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .WRAP_LIMIT(LIMIT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";

  int m_prev, m_state, m_wrap;
  bit m_alarm;

  int t1[5] = '{13, 14, 15, 0, 1};
  int t2[5] = '{2, 1, 0, 15, 14};
  int t3[4] = '{9, 9, 4, 5};
  int t5[6] = '{14, 15, 0, 1, 14, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, want);
    end
  endtask

  // Behavioural reference: 0 INIT, 1 HOLD, 2 UP, 3 DOWN
  task automatic model(input int v, input bit c, input bit r, output exp_t e);
    bit up, dn, hd;
    int ns;
    e.ovf = 0; e.unf = 0; e.jump = 0;
    if (r) begin
      m_prev = 0; m_state = 0; m_wrap = 0; m_alarm = 0;
    end else begin
      up = (v == (m_prev + 1) % MODV);
      dn = (v == (m_prev + MODV - 1) % MODV);
      hd = (v == m_prev);
      if (m_state == 0) ns = 1;
      else if (up) begin ns = 2; e.ovf = (m_prev == MAXV); end
      else if (dn) begin ns = 3; e.unf = (m_prev == 0); end
      else if (hd) ns = 1;
      else begin ns = 1; e.jump = 1; end
      if (c) begin
        m_wrap = 0; m_alarm = 0;
        e.ovf = 0; e.unf = 0; e.jump = 0;
      end else if (e.ovf || e.unf) begin
        if (m_wrap < WSAT) m_wrap++;
        if (m_wrap >= LIMIT) m_alarm = 1;
      end
      m_prev  = v;
      m_state = ns;
    end
    e.st    = m_state[1:0];
    e.wrap  = m_wrap;
    e.alarm = m_alarm;
  endtask

  task automatic step(input int v, input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.count_in = v[WIDTH-1:0];
    bus.clr      = c;
    model(v, c, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ovf",       32'(bus.ovf),       32'(e.ovf));
      chk("unf",       32'(bus.unf),       32'(e.unf));
      chk("jump",      32'(bus.jump),      32'(e.jump));
      chk("dir_state", 32'(bus.dir_state), 32'(e.st));
      chk("wrap_cnt",  32'(bus.wrap_cnt),  32'(e.wrap));
      chk("alarm",     32'(bus.alarm),     32'(e.alarm));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.count_in = '0;
    bus.clr      = 1'b0;

    phase = "reset";
    step(0, 0, 1);
    step(0, 0, 1);

    phase = "t1_up_ovf";
    foreach (t1[i]) step(t1[i], 0, 0);

    phase = "t2_down_unf";
    foreach (t2[i]) step(t2[i], 0, 0);

    phase = "t3_hold_jump";
    foreach (t3[i]) step(t3[i], 0, 0);

    phase = "t4_alarm";
    step(0, 0, 1);
    for (int k = 0; k < 55; k++) step(k % MODV, 0, 0);
    step(55 % MODV, 1, 0);
    step(56 % MODV, 0, 0);
    step(57 % MODV, 0, 0);

    phase = "t5_clr_wins";
    foreach (t5[i]) step(t5[i], 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);

    phase = "sat";
    step(0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      step(15, 0, 0);
      step(0, 0, 0);
    end

    phase = "t6_midreset";
    step(14, 0, 0);
    step(15, 0, 0);
    step(3, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
